fifo_sync: RTL

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_sync_pkg.sv | 11 +
 rtl/dpram.sv | 39 +++
 rtl/fifo_sync.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fifo_sync_pkg.sv
// Shared helpers for the synchronous FIFO slice.
// Holds only generic arithmetic; sizing and thresholds stay as module parameters.
package fifo_sync_pkg;

  // Increment with wrap at an arbitrary (not necessarily power-of-two) modulus.
  function automatic int unsigned wrap_inc(input int unsigned value,
                                           input int unsigned modulus);
    return ((value + 32'd1) >= modulus) ? 32'd0 : (value + 32'd1);
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// Read data is registered and holds its value when re is low.
module dpram #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic              wclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rclk,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned WORDS = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem [WORDS];

  // Preloading is not supported in this RTL flavour; reject a non-empty file name.
  if (INIT_FILE != "") begin : g_no_init
    $error("dpram: INIT_FILE preload is not supported");
  end

  always_ff @(posedge wclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge rclk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO over dpram with arbitrary depth, registered count and flags.
// Optional sticky overflow/underflow reporting is enabled by defining FIFO_SYNC_ERR_EN.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WORDS_TOTAL = 32'd1 << ADDR_W,
  parameter int unsigned AFULL_THR   = WORDS_TOTAL - 32'd1,
  parameter int unsigned AEMPTY_THR  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic [ADDR_W:0]   load
`ifdef FIFO_SYNC_ERR_EN
  ,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int unsigned LOAD_W = ADDR_W + 32'd1;
  localparam logic [ADDR_W:0] DEPTH    = LOAD_W'(WORDS_TOTAL);
  localparam logic [ADDR_W:0] AFULL_L  = LOAD_W'(AFULL_THR);
  localparam logic [ADDR_W:0] AEMPTY_L = LOAD_W'(AEMPTY_THR);

  if ((WORDS_TOTAL < 32'd2) || (WORDS_TOTAL > (32'd1 << ADDR_W))) begin : g_bad_depth
    $error("fifo_sync: WORDS_TOTAL must lie in 2..2**ADDR_W");
  end
  if (!((AEMPTY_THR < AFULL_THR) && (AFULL_THR <= WORDS_TOTAL))) begin : g_bad_thr
    $error("fifo_sync: thresholds must satisfy AEMPTY_THR < AFULL_THR <= WORDS_TOTAL");
  end

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [ADDR_W:0]   load_nxt;
  logic              wr, rd;

  // Accepted transfers; rst and flush suppress both, which also keeps the RAM untouched.
  always_comb begin
    wr = 1'b0;
    rd = 1'b0;
    if (!rst && !flush) begin
      wr = wen && !full;
      rd = ren && !empty;
    end
  end

  // Next pointer and count; flush (and rst) return everything to the empty state.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    load_nxt   = load;
    if (rst || flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      load_nxt   = '0;
    end else begin
      if (wr) begin
        wr_ptr_nxt = ADDR_W'(wrap_inc(32'(wr_ptr), WORDS_TOTAL));
      end
      if (rd) begin
        rd_ptr_nxt = ADDR_W'(wrap_inc(32'(rd_ptr), WORDS_TOTAL));
      end
      case ({wr, rd})
        2'b10:   load_nxt = load + LOAD_W'(1);
        2'b01:   load_nxt = load - LOAD_W'(1);
        default: load_nxt = load;
      endcase
    end
  end

  // Flags are registered from the next count so they always match load.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      load   <= '0;
      rvalid <= 1'b0;
      empty  <= 1'b1;
      full   <= 1'b0;
      aempty <= 1'b1;
      afull  <= (AFULL_THR == 32'd0);
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      load   <= load_nxt;
      rvalid <= rd;
      empty  <= (load_nxt == '0);
      full   <= (load_nxt == DEPTH);
      aempty <= (load_nxt <= AEMPTY_L);
      afull  <= (load_nxt >= AFULL_L);
    end
  end

`ifdef FIFO_SYNC_ERR_EN
  // Sticky error flags; a new event in the same cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wen && full && !flush) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (ren && empty && !flush) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`endif

  dpram #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_FILE ("")
  ) u_ram (
    .wclk  (clk),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata (wdata),
    .rclk  (clk),
    .re    (rd),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule
